// File: rtl/div32x16_pkg.sv
// Shared types and constants for the div32x16_seq restoring divider.
package div32x16_pkg;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int STEPS      = 16;

  localparam logic [DIVISOR_W-1:0] SAT_QUOTIENT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div32x16_seq_if.sv
// Operand/result handshake bundle for div32x16_seq.
interface div32x16_seq_if;
  import div32x16_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVISOR_W-1:0]  quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div32x16_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, try-subtract the divisor.
module div32x16_step
  import div32x16_pkg::*;
(
  input  logic [DIVISOR_W:0]   prem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] dvs_i,
  output logic [DIVISOR_W:0]   prem_o,
  output logic                 q_o
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W:0]   diff;

  assign shifted = {prem_i, bit_i};
  assign q_o     = (shifted >= {2'b00, dvs_i});
  // When the subtraction succeeds the true difference is below the divisor, so 17 bits hold it.
  assign diff    = shifted[DIVISOR_W:0] - {1'b0, dvs_i};
  assign prem_o  = q_o ? diff : shifted[DIVISOR_W:0];

endmodule

// File: rtl/div32x16_seq.sv
// Sequential 32/16 restoring divider, one quotient bit per cycle.
// Define DIV32X16_SIGNED_EN for two's-complement operands; default build is unsigned.
module div32x16_seq
  import div32x16_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  div32x16_seq_if.slave  bus
);

  div_state_t            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DIVISOR_W-1:0]  quo_q, quo_d, rem_q, rem_d;
  logic                  dbz_q, dbz_d, ovf_q, ovf_d;

  // Upper half holds |dividend|[31:16]; lower half shifts dividend bits out and quotient bits in.
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W:0]    prem_q, prem_d;
  logic [DIVISOR_W:0]    step_prem;
  logic                  step_q;

`ifdef DIV32X16_SIGNED_EN
  logic                  qneg_q, qneg_d, rneg_q, rneg_d;
  logic [DIVISOR_W-1:0]  raw_lo_q, raw_lo_d;

  function automatic logic [DIVISOR_W-1:0] neg_if(input logic [DIVISOR_W-1:0] v, input logic n);
    return n ? (~v + 16'd1) : v;
  endfunction

  function automatic logic sat_check(input logic [DIVISOR_W-1:0] qmag, input logic n);
    return n ? (qmag > 16'h8000) : (qmag > 16'h7FFF);
  endfunction
`endif

  div32x16_step u_step (
    .prem_i (prem_q),
    .bit_i  (dvd_q[DIVISOR_W-1]),
    .dvs_i  (dvs_q),
    .prem_o (step_prem),
    .q_o    (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
`ifdef DIV32X16_SIGNED_EN
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    raw_lo_d = raw_lo_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = PREP;
`ifdef DIV32X16_SIGNED_EN
          dvd_d    = bus.dividend[DIVIDEND_W-1] ? (~bus.dividend + 32'd1) : bus.dividend;
          dvs_d    = bus.divisor[DIVISOR_W-1] ? (~bus.divisor + 16'd1) : bus.divisor;
          qneg_d   = bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
          rneg_d   = bus.dividend[DIVIDEND_W-1];
          raw_lo_d = bus.dividend[DIVISOR_W-1:0];
`else
          dvd_d    = bus.dividend;
          dvs_d    = bus.divisor;
`endif
        end
      end
      PREP: begin
        if (dvs_q == '0) begin
          state_d = DONE;
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
          quo_d   = SAT_QUOTIENT;
`ifdef DIV32X16_SIGNED_EN
          rem_d   = raw_lo_q;
`else
          rem_d   = dvd_q[DIVISOR_W-1:0];
`endif
        end else if (dvd_q[DIVIDEND_W-1:DIVISOR_W] >= dvs_q) begin
          state_d = DONE;
          dbz_d   = 1'b0;
          ovf_d   = 1'b1;
          quo_d   = SAT_QUOTIENT;
          rem_d   = '0;
        end else begin
          state_d = CALC;
          cnt_d   = '0;
          prem_d  = {1'b0, dvd_q[DIVIDEND_W-1:DIVISOR_W]};
        end
      end
      CALC: begin
        prem_d                = step_prem;
        dvd_d[DIVISOR_W-1:0]  = {dvd_q[DIVISOR_W-2:0], step_q};
        cnt_d                 = cnt_q + 4'd1;
        if (cnt_q == 4'(STEPS - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        dbz_d   = 1'b0;
`ifdef DIV32X16_SIGNED_EN
        if (sat_check(dvd_q[DIVISOR_W-1:0], qneg_q)) begin
          ovf_d = 1'b1;
          quo_d = SAT_QUOTIENT;
          rem_d = '0;
        end else begin
          ovf_d = 1'b0;
          quo_d = neg_if(dvd_q[DIVISOR_W-1:0], qneg_q);
          rem_d = neg_if(prem_q[DIVISOR_W-1:0], rneg_q);
        end
`else
        ovf_d   = 1'b0;
        quo_d   = dvd_q[DIVISOR_W-1:0];
        rem_d   = prem_q[DIVISOR_W-1:0];
`endif
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Working operands need no reset: they are always reloaded before being consumed.
  always_ff @(posedge clk) begin
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
    prem_q <= prem_d;
`ifdef DIV32X16_SIGNED_EN
    qneg_q   <= qneg_d;
    rneg_q   <= rneg_d;
    raw_lo_q <= raw_lo_d;
`endif
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_div32x16_seq.sv
// Directed self-checking bench for div32x16_seq (unsigned default build, signed cases under DIV32X16_SIGNED_EN).
module tb_div32x16_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  div32x16_seq_if bus();

  div32x16_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic issue(input logic [31:0] a, input logic [15:0] b);
    for (int i = 0; i < 40 && !bus.in_ready; i++) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = ~b;
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.dividend = '0;   bus.divisor = '0;
    #12;
    checks++;
    if ({bus.out_valid, bus.div_by_zero, bus.overflow, bus.in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0001", {bus.out_valid, bus.div_by_zero, bus.overflow, bus.in_ready});
    end
    checks++;
    if ({bus.quotient, bus.remainder} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 00000000", {bus.quotient, bus.remainder});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_basic();
    int lat;
    issue(32'd100, 16'd7);
    wait_result(lat);
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL basic_latency: got %0d want 18", lat); end
    checks++;
    if ({bus.quotient, bus.remainder} !== {16'h000E, 16'h0002}) begin
      errors++; $display("FAIL basic_qr: got %h want 000e0002", {bus.quotient, bus.remainder});
    end
    checks++;
    if ({bus.div_by_zero, bus.overflow} !== 2'b00) begin
      errors++; $display("FAIL basic_flags: got %b want 00", {bus.div_by_zero, bus.overflow});
    end
    ack();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_div_by_zero();
    int lat;
    issue(32'h1234_5678, 16'h0000);
    wait_result(lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    checks++;
    if ({bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder} !== {2'b10, 16'hFFFF, 16'h5678}) begin
      errors++;
      $display("FAIL dbz_result: got dbz=%b ovf=%b q=%h r=%h want dbz=1 ovf=0 q=ffff r=5678",
               bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder);
    end
    ack();
  endtask

  task automatic test_overflow();
    int lat;
    issue(32'h0001_0000, 16'h0001);
    wait_result(lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL ovf_latency: got %0d want 1", lat); end
    checks++;
    if ({bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder} !== {2'b01, 16'hFFFF, 16'h0000}) begin
      errors++;
      $display("FAIL ovf_result: got dbz=%b ovf=%b q=%h r=%h want dbz=0 ovf=1 q=ffff r=0000",
               bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder);
    end
    ack();
`ifdef DIV32X16_SIGNED_EN
    issue(32'h0000_8000, 16'h0001);
    wait_result(lat);
    checks++;
    if ({lat == 18, bus.overflow, bus.quotient, bus.remainder} !== {2'b11, 16'hFFFF, 16'h0000}) begin
      errors++;
      $display("FAIL sovf_8000: got lat=%0d ovf=%b q=%h r=%h want lat=18 ovf=1 q=ffff r=0000",
               lat, bus.overflow, bus.quotient, bus.remainder);
    end
    ack();
`endif
  endtask

`ifdef DIV32X16_SIGNED_EN
  task automatic test_signed();
    int lat;
    issue(32'hFFFF_FF9C, 16'd7);
    wait_result(lat);
    checks++;
    if ({bus.overflow, bus.quotient, bus.remainder} !== {1'b0, 16'hFFF2, 16'hFFFE}) begin
      errors++;
      $display("FAIL signed_neg100_7: got ovf=%b q=%h r=%h want ovf=0 q=fff2 r=fffe",
               bus.overflow, bus.quotient, bus.remainder);
    end
    ack();
    issue(32'hC000_0000, 16'h8000);
    wait_result(lat);
    checks++;
    if ({lat == 18, bus.overflow, bus.quotient, bus.remainder} !== {2'b11, 16'hFFFF, 16'h0000}) begin
      errors++;
      $display("FAIL signed_c000_8000: got lat=%0d ovf=%b q=%h r=%h want lat=18 ovf=1 q=ffff r=0000",
               lat, bus.overflow, bus.quotient, bus.remainder);
    end
    ack();
    issue(32'hFFFF_8000, 16'h0001);
    wait_result(lat);
    checks++;
    if ({bus.overflow, bus.quotient, bus.remainder} !== {1'b0, 16'h8000, 16'h0000}) begin
      errors++;
      $display("FAIL signed_min_1: got ovf=%b q=%h r=%h want ovf=0 q=8000 r=0000",
               bus.overflow, bus.quotient, bus.remainder);
    end
    ack();
  endtask
`endif

  task automatic test_backpressure();
    int lat;
    issue(32'd1000, 16'd3);
    wait_result(lat);
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL bp_latency: got %0d want 18", lat); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder} !== {2'b10, 16'h014D, 16'h0001}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b q=%h r=%h want vld=1 rdy=0 q=014d r=0001",
                 i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder);
      end
    end
    ack();
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++; $display("FAIL bp_release: got rdy/vld=%b want 10", {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(32'h0012_3456, 16'h0100);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.div_by_zero, bus.overflow, bus.in_ready, bus.quotient, bus.remainder}
        !== {4'b0001, 32'h0}) begin
      errors++;
      $display("FAIL midreset_state: got vld=%b dbz=%b ovf=%b rdy=%b q=%h r=%h want 0 0 0 1 0000 0000",
               bus.out_valid, bus.div_by_zero, bus.overflow, bus.in_ready, bus.quotient, bus.remainder);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(32'h0000_FFFE, 16'd2);
    wait_result(lat);
    checks++;
    if ({lat == 18, bus.overflow, bus.quotient, bus.remainder} !== {2'b10, 16'h7FFF, 16'h0000}) begin
      errors++;
      $display("FAIL midreset_after: got lat=%0d ovf=%b q=%h r=%h want lat=18 ovf=0 q=7fff r=0000",
               lat, bus.overflow, bus.quotient, bus.remainder);
    end
    ack();
  endtask

  task automatic test_reverse();
    logic [31:0] p [4];
    logic [15:0] x [4];
    logic [15:0] y [4];
    int lat;
    p[0] = 32'd60000;   x[0] = 16'd300;  y[0] = 16'd200;
    p[1] = 32'd1000000; x[1] = 16'd1000; y[1] = 16'd1000;
    p[2] = 32'h0000_FFFF; x[2] = 16'h00FF; y[2] = 16'h0101;
`ifdef DIV32X16_SIGNED_EN
    p[3] = 32'hFFFF_15A0; x[3] = 16'd200; y[3] = 16'hFED4;
`else
    p[3] = 32'hFFFE_0001; x[3] = 16'hFFFF; y[3] = 16'hFFFF;
`endif
    for (int i = 0; i < 4; i++) begin
      issue(p[i], x[i]);
      wait_result(lat);
      checks++;
      if ({lat == 18, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder}
          !== {3'b100, y[i], 16'h0000}) begin
        errors++;
        $display("FAIL reverse[%0d] %h/%h: got lat=%0d dbz=%b ovf=%b q=%h r=%h want lat=18 flags=0 q=%h r=0000",
                 i, p[i], x[i], lat, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder, y[i]);
      end
      ack();
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.dividend  = 32'd500;
    bus.divisor   = 16'd9;
    t0 = -1; t1 = -1;
    for (int n = 0; n < 60 && t1 < 0; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid && t0 < 0) t0 = n;
      else if (bus.out_valid && t0 >= 0) t1 = n;
    end
    bus.in_valid  = 1'b0;
    checks++;
    if (t1 - t0 !== 20) begin errors++; $display("FAIL b2b_period: got %0d want 20", t1 - t0); end
    checks++;
    if ({bus.quotient, bus.remainder} !== {16'd55, 16'd5}) begin
      errors++; $display("FAIL b2b_qr: got %h want 00370005", {bus.quotient, bus.remainder});
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    repeat (25) begin @(posedge clk); #1; end
    if (bus.out_valid) ack();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unsigned_basic();
    test_div_by_zero();
    test_overflow();
`ifdef DIV32X16_SIGNED_EN
    test_signed();
`endif
    test_backpressure();
    test_reset_mid();
    test_reverse();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
